csa_final_add: RTL and testbench



---
 rtl/ntt_pkg.sv | 28 ++
 rtl/seg_add_stage.sv | 59 +++++
 rtl/csa_final_add.sv | 111 +++++++++++
 tb/tb_csa_final_add.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared helpers for the NTT multiplier datapath: segment count and 3:2 compression.
package ntt_pkg;

    // Widest operand the 3:2 compressor helper supports; callers zero-extend into it.
    localparam int CSA_W_MAX = 1024;

    typedef logic [CSA_W_MAX-1:0] csa_word_t;

    // Sum and carry rows of one carry-save compression.
    typedef struct packed {
        csa_word_t s;
        csa_word_t c;
    } csa_pair_t;

    // Number of carry-propagate segments across an n-bit word.
    function automatic int nseg(input int n, input int seg);
        return n / seg;
    endfunction

    // One full-adder layer: sum row is the parity and carry row is the majority shifted up one bit.
    function automatic csa_pair_t csa3to2(input csa_word_t a, input csa_word_t b, input csa_word_t c);
        csa_pair_t r;
        r.s = a ^ b ^ c;
        r.c = ((a & b) | (a & c) | (b & c)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/seg_add_stage.sv
// One carry-propagate segment: resolves SEG bits of the running sum and forwards everything else.
module seg_add_stage
    import ntt_pkg::*;
#(
    parameter int N   = 64,
    parameter int SEG = 16,
    parameter int K   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         vld_i,
    input  logic         carry_i,
    input  logic [N-1:0] r_i,
    input  logic [N-1:0] c_i,
    output logic         vld_o,
    output logic         carry_o,
    output logic [N-1:0] r_o,
    output logic [N-1:0] c_o
);

    // Bit offset of the segment this stage resolves.
    localparam int LO = (K - 1) * SEG;

    logic [SEG:0]   seg_sum;
    logic [N-1:0]   r_d;
    logic           vld_q;
    logic           carry_q;
    logic [N-1:0]   r_q;
    logic [N-1:0]   c_q;

    // Add this segment of the sum and carry rows; lower (resolved) and upper (pending) bits pass through.
    always_comb begin
        seg_sum         = {1'b0, r_i[LO +: SEG]} + {1'b0, c_i[LO +: SEG]} + {{SEG{1'b0}}, carry_i};
        r_d             = r_i;
        r_d[LO +: SEG]  = seg_sum[SEG-1:0];
    end

    // Stage register; holds everything when the pipe is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q   <= 1'b0;
            carry_q <= 1'b0;
            r_q     <= '0;
            c_q     <= '0;
        end else if (en) begin
            vld_q   <= vld_i;
            carry_q <= seg_sum[SEG];
            r_q     <= r_d;
            c_q     <= c_i;
        end
    end

    assign vld_o   = vld_q;
    assign carry_o = carry_q;
    assign r_o     = r_q;
    assign c_o     = c_q;

endmodule

// File: rtl/csa_final_add.sv
// Final 3:2 compression plus segmented pipelined carry-propagate adder with valid/ready flow control.
module csa_final_add
    import ntt_pkg::*;
#(
    parameter int N   = 64,
    parameter int SEG = 16,
    parameter int IN  = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] csa_in [IN-1:0],
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum_out
);

    localparam int NSEG = nseg(N, SEG);

    if (N % SEG != 0) begin : g_bad_seg
        $error("csa_final_add: N must be a multiple of SEG");
    end
    if (IN != 2 && IN != 3) begin : g_bad_in
        $error("csa_final_add: IN must be 2 or 3");
    end
    if (N > CSA_W_MAX) begin : g_bad_width
        $error("csa_final_add: N exceeds the compressor helper width");
    end

    logic         adv;
    logic [N-1:0] s0_d;
    logic [N-1:0] c0_d;
    logic         vld0_q;
    logic [N-1:0] r0_q;
    logic [N-1:0] c0_q;

    logic         vld_p   [0:NSEG];
    logic         carry_p [0:NSEG];
    logic [N-1:0] r_p     [0:NSEG];
    logic [N-1:0] c_p     [0:NSEG];

    // Whole pipe moves together: it advances unless a finished result is waiting on downstream.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    if (IN == 3) begin : g_csa3
        // Bits above N are the truncated part of the wide compressor result.
        csa_pair_t pair_unused_msbs;

        // Collapse three rows to sum and carry rows, carry-out past bit N-1 dropped.
        always_comb begin
            pair_unused_msbs = csa3to2(csa_word_t'(csa_in[0]), csa_word_t'(csa_in[1]),
                                       csa_word_t'(csa_in[2]));
            s0_d = pair_unused_msbs.s[N-1:0];
            c0_d = pair_unused_msbs.c[N-1:0];
        end
    end else begin : g_rows2
        // Two rows are already in sum/carry form.
        always_comb begin
            s0_d = csa_in[0];
            c0_d = csa_in[1];
        end
    end

    // Compression register; a bubble enters whenever the pipe advances without valid input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld0_q <= 1'b0;
            r0_q   <= '0;
            c0_q   <= '0;
        end else if (adv) begin
            vld0_q <= in_valid;
            r0_q   <= s0_d;
            c0_q   <= c0_d;
        end
    end

    assign vld_p[0]   = vld0_q;
    assign carry_p[0] = 1'b0;
    assign r_p[0]     = r0_q;
    assign c_p[0]     = c0_q;

    for (genvar k = 1; k <= NSEG; k++) begin : g_seg
        seg_add_stage #(
            .N   (N),
            .SEG (SEG),
            .K   (k)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en      (adv),
            .vld_i   (vld_p[k-1]),
            .carry_i (carry_p[k-1]),
            .r_i     (r_p[k-1]),
            .c_i     (c_p[k-1]),
            .vld_o   (vld_p[k]),
            .carry_o (carry_p[k]),
            .r_o     (r_p[k]),
            .c_o     (c_p[k])
        );
    end

    // Top carry and the leftover carry row are discarded: the result is modulo 2^N.
    logic tail_unused;
    assign tail_unused = ^{c_p[NSEG], carry_p[NSEG]};

    assign out_valid = vld_p[NSEG];
    assign sum_out   = r_p[NSEG];

endmodule

// File: tb/tb_csa_final_add.sv
module tb_csa_final_add;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] csa_in [2:0];
    logic [63:0] sum_out;

    logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
    logic [31:0] d2_in [1:0];
    logic [31:0] d2_sum_out;

    int          ncmp, nfail;
    int          tickno, nret, first_ret, last_ret;
    logic [63:0] expq [$];
    logic [63:0] held;

    always #5 clk = ~clk;

    csa_final_add dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .csa_in    (csa_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out)
    );

    csa_final_add #(.N(32), .SEG(8), .IN(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (d2_in_valid),
        .in_ready  (d2_in_ready),
        .csa_in    (d2_in),
        .out_valid (d2_out_valid),
        .out_ready (d2_out_ready),
        .sum_out   (d2_sum_out)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic randomize_rows();
        for (int i = 0; i < 3; i++) csa_in[i] = {$urandom, $urandom};
    endtask

    // One clock of the streaming scoreboard: settle, monitor handshakes, advance to 1 after the edge.
    task automatic tick();
        logic acc, ret;
        #1;
        acc = in_valid && in_ready;
        ret = out_valid && out_ready;
        if (ret) begin
            check("queue_nonempty", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) check("stream_data", sum_out, expq.pop_front());
            if (first_ret < 0) first_ret = tickno;
            last_ret = tickno;
            nret++;
        end
        if (acc) expq.push_back(csa_in[0] + csa_in[1] + csa_in[2]);
        tickno++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        in_valid = 1'b0;
        for (int i = 0; i < budget && expq.size() > 0; i++) tick();
        check("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    // Single operand through an empty pipe with exact latency checking (accept edge counts as edge 1).
    task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [63:0] exp);
        csa_in[0] = a; csa_in[1] = b; csa_in[2] = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
            if (e < 5) check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"}, sum_out, exp);
        @(posedge clk);
        #1;
        check({tag, "_retired"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run2(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        d2_in[0] = a; d2_in[1] = b;
        d2_in_valid = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            d2_in_valid = 1'b0;
            if (e < 5) check({tag, "_early_valid"}, 64'(d2_out_valid), 64'd0);
        end
        check({tag, "_valid"}, 64'(d2_out_valid), 64'd1);
        check({tag, "_sum"}, 64'(d2_sum_out), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra, rb;
        ncmp = 0; nfail = 0; tickno = 0; nret = 0; first_ret = -1; last_ret = -1;
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) csa_in[i] = '0;
        d2_in_valid = 1'b0; d2_out_ready = 1'b1;
        d2_in[0] = '0; d2_in[1] = '0;

        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum_out", sum_out, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_d2_out_valid", 64'(d2_out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed: basic sum, full wrap, ripple across three segments.
        run_one("basic", 64'd1, 64'd2, 64'd3, 64'd6);
        run_one("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0);
        run_one("ripple", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'h0001_0000_0000_0000);
        run_one("allones3", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD);

        // Streaming: 100 back-to-back random triples, results must be contiguous.
        nret = 0; first_ret = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            randomize_rows();
            in_valid = 1'b1;
            tick();
        end
        drain(40);
        check("stream_count", 64'(nret), 64'd100);
        check("stream_consecutive", 64'(last_ret - first_ret + 1), 64'd100);

        // Backpressure: 7-cycle stall mid-stream.
        for (int i = 0; i < 30; i++) begin
            randomize_rows();
            in_valid = 1'b1;
            if (i == 15) begin
                check("bp_valid_before", 64'(out_valid), 64'd1);
                out_ready = 1'b0;
                held = sum_out;
                for (int k = 0; k < 7; k++) begin
                    randomize_rows();
                    tick();
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_out_valid", 64'(out_valid), 64'd1);
                    check("bp_sum_held", sum_out, held);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        drain(40);

        // Reset with three operands in flight.
        for (int i = 0; i < 3; i++) begin
            randomize_rows();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum_out", sum_out, 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        expq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_quiet", 64'(out_valid), 64'd0);
        end

        // Two-row, 8-bit-segment, 32-bit variant.
        run2("d2_dir", 32'h8000_0000, 32'h8000_0001, 32'h0000_0001);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            run2("d2_rand", ra, rb, ra + rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
